// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared channel state type and 50 MHz default timings
package button_conditioner_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} btn_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEF_REPEAT_RATE_CYCLES = 5_000_000;
  localparam bit DEF_ACTIVE_LOW = 1'b1;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: pad inputs and conditioned button outputs
interface button_conditioner_if #(parameter int N_BTN = 4);
  logic [N_BTN-1:0] key_raw;
  logic [N_BTN-1:0] buttons_export;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] repeat_pulse;
  modport master (output key_raw, input buttons_export, press_pulse, release_pulse, repeat_pulse);
  modport slave (input key_raw, output buttons_export, press_pulse, release_pulse, repeat_pulse);
endinterface

// File: rtl/button_conditioner_debounce_ch.sv
// btn_debounce_ch: one button channel (sync, debounce FSM, optional hold-to-repeat via BUTTON_CONDITIONER_REPEAT_EN)
module btn_debounce_ch
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce_ch: invalid cycle-count parameters");
  end
  logic [1:0] sync_q;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic press_q, press_d, release_q, release_d;
  logic s, lvl, pend, chg, done;
  assign s = sync_q[1];
  assign lvl = state_q inside {PRESSED, RELEASE_PEND};
  assign pend = state_q inside {PRESS_PEND, RELEASE_PEND};
  assign chg = s ^ lvl;
  assign done = pend && chg && cnt_q == CNT_MAX;
  // two-flop synchroniser; reset value is the released level
  always_ff @(posedge clk)
    if (rst) sync_q <= '0;
    else sync_q <= {sync_q[0], s_i};
  // debounce: a pending change must survive DEBOUNCE_CYCLES further samples before it is accepted
  always_comb begin
    state_d = !chg ? (lvl ? PRESSED : RELEASED) :
              done ? (lvl ? RELEASED : PRESSED) :
              !pend ? (lvl ? RELEASE_PEND : PRESS_PEND) : state_q;
    cnt_d = (!chg || done) ? '0 : pend ? cnt_q + CW'(1) : CW'(1);
    press_d = done && !lvl;
    release_d = done && lvl;
  end
  // channel state, debounce counter and event pulses
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RELEASED;
      cnt_q <= '0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  assign level_o = lvl;
  assign press_o = press_q;
  assign release_o = release_q;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int HW = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic started_q, started_d, rep_q, rep_d, running, due;
  // hold counter restarts on every entry to PRESSED and after each repeat; the release cycle wins over a due repeat
  always_comb begin
    running = lvl && !release_d && !(state_d == PRESSED && state_q != PRESSED);
    hold_inc = hold_q + HW'(1);
    due = hold_inc == (started_q ? HW'(REPEAT_RATE_CYCLES) : HW'(REPEAT_DELAY_CYCLES));
    rep_d = running && due;
    hold_d = (!running || due) ? '0 : hold_inc;
    started_d = running && (started_q || due);
  end
  // hold counter and repeat pulse registers
  always_ff @(posedge clk)
    if (rst) begin
      hold_q <= '0;
      started_q <= 1'b0;
      rep_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      started_q <= started_d;
      rep_q <= rep_d;
    end
  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-button sync/debounce/edge pulses for the KEY pads (repeat via BUTTON_CONDITIONER_REPEAT_EN)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter bit ACTIVE_LOW = DEF_ACTIVE_LOW,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES = DEF_REPEAT_RATE_CYCLES
) (
  input logic clk_clk,
  input logic reset_reset,
  button_conditioner_if.slave io
);
  logic [N_BTN-1:0] s_raw, lvl, prs, rel, rep;
  assign s_raw = ACTIVE_LOW ? ~io.key_raw : io.key_raw;
  assign io.buttons_export = ACTIVE_LOW ? ~lvl : lvl;
  assign io.press_pulse = prs;
  assign io.release_pulse = rel;
  assign io.repeat_pulse = rep;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk(clk_clk),
      .rst(reset_reset),
      .s_i(s_raw[i]),
      .level_o(lvl[i]),
      .press_o(prs[i]),
      .release_o(rel[i]),
      .repeat_o(rep[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus, run-length reference model and literal checkpoints
module tb_button_conditioner;
  localparam int N = 4, D = 8, RD = 32, RR = 10;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  button_conditioner_if #(.N_BTN(N)) bus_if ();
  button_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .io(bus_if.slave)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: pad seen two edges late; a level flips after D+1 consecutive differing samples;
  // repeats fall at RD, RD+RR, ... cycles after the last (re)entry into the pressed level.
  logic [3:0] p1, p2, s_m, lvl_m, prs_m, rel_m, rep_m;
  int run[N], anchor[N];
  int cyc = 0;
  bit live = 1'b0;
  always @(posedge clk) begin
    cyc++;
    prs_m = '0; rel_m = '0; rep_m = '0;
    if (rst) begin
      p1 = '0; p2 = '0; lvl_m = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      s_m = p2; p2 = p1; p1 = ~bus_if.key_raw;
      for (int i = 0; i < N; i++) begin
        if (s_m[i] != lvl_m[i]) begin
          run[i]++;
          if (run[i] == D + 1) begin
            lvl_m[i] = s_m[i];
            prs_m[i] = s_m[i];
            rel_m[i] = !s_m[i];
            run[i] = 0;
            anchor[i] = cyc;
          end
        end else begin
          if (run[i] > 0 && lvl_m[i]) anchor[i] = cyc;
          run[i] = 0;
        end
        if (REP && lvl_m[i] && cyc - anchor[i] >= RD && (cyc - anchor[i] - RD) % RR == 0) rep_m[i] = 1'b1;
      end
    end
    live = 1'b1;
  end

  always @(negedge clk)
    if (live) begin
      chk("model buttons_export", bus_if.buttons_export, ~lvl_m);
      chk("model press_pulse", bus_if.press_pulse, prs_m);
      chk("model release_pulse", bus_if.release_pulse, rel_m);
      chk("model repeat_pulse", bus_if.repeat_pulse, rep_m);
    end

  logic [3:0] rep_exp;
  initial begin
    rep_exp = REP ? 4'b1000 : 4'b0000;
    bus_if.key_raw = 4'hF;
    tick(3);
    chk("reset buttons_export", bus_if.buttons_export, 4'b1111);
    chk("reset press", bus_if.press_pulse, 4'b0000);
    chk("reset release", bus_if.release_pulse, 4'b0000);
    chk("reset repeat", bus_if.repeat_pulse, 4'b0000);
    rst = 1'b0;
    tick(2);
    bus_if.key_raw[0] = 1'b0;
    tick(10);
    chk("press k+9 export", bus_if.buttons_export, 4'b1111);
    chk("press k+9 pulse", bus_if.press_pulse, 4'b0000);
    tick(1);
    chk("press k+10 export", bus_if.buttons_export, 4'b1110);
    chk("press k+10 pulse", bus_if.press_pulse, 4'b0001);
    tick(1);
    chk("press k+11 pulse", bus_if.press_pulse, 4'b0000);
    bus_if.key_raw[1] = 1'b0; tick(5);
    bus_if.key_raw[1] = 1'b1; tick(1);
    bus_if.key_raw[1] = 1'b0; tick(5);
    bus_if.key_raw[1] = 1'b1; tick(12);
    chk("bounce export", bus_if.buttons_export, 4'b1110);
    bus_if.key_raw[0] = 1'b1;
    bus_if.key_raw[2] = 1'b0;
    tick(10);
    chk("simul k+9 export", bus_if.buttons_export, 4'b1110);
    tick(1);
    chk("simul release", bus_if.release_pulse, 4'b0001);
    chk("simul press", bus_if.press_pulse, 4'b0100);
    chk("simul export", bus_if.buttons_export, 4'b1011);
    tick(2);
    bus_if.key_raw[3] = 1'b0;
    tick(11);
    chk("hold press", bus_if.press_pulse, 4'b1000);
    chk("hold export", bus_if.buttons_export, 4'b0011);
    tick(32);
    chk("repeat +32", bus_if.repeat_pulse, rep_exp);
    tick(10);
    chk("repeat +42", bus_if.repeat_pulse, rep_exp);
    tick(9);
    bus_if.key_raw[3] = 1'b1;
    tick(1);
    chk("repeat +52", bus_if.repeat_pulse, rep_exp);
    tick(10);
    chk("hold release", bus_if.release_pulse, 4'b1000);
    chk("repeat suppressed", bus_if.repeat_pulse, 4'b0000);
    chk("hold release export", bus_if.buttons_export, 4'b1011);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("midreset export", bus_if.buttons_export, 4'b1111);
    chk("midreset press", bus_if.press_pulse, 4'b0000);
    rst = 1'b0;
    tick(10);
    chk("postreset k+9 press", bus_if.press_pulse, 4'b0000);
    tick(1);
    chk("postreset press", bus_if.press_pulse, 4'b0100);
    chk("postreset export", bus_if.buttons_export, 4'b1011);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
